// File: rtl/seq_detector_ctrl_if.sv
// ============================================================================
//  Module   : seq_detector_ctrl_if
//  Brief    : Requester/datapath bundle for the shared sequence-detector controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_detector_ctrl_if #(
  parameter int WIDTH = 7,
  parameter int NREQ  = 2,
  parameter int CNT_W = 8
);
  localparam int OWNER_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_seq;
  logic                  data_in;
  logic [NREQ-1:0]       gnt;
  logic [OWNER_W-1:0]    owner;
  logic                  active;
  logic                  match;
  logic [CNT_W-1:0]      match_cnt;

  modport master (
    output req, req_seq, data_in,
    input  gnt, owner, active, match, match_cnt
  );

  modport slave (
    input  req, req_seq, data_in,
    output gnt, owner, active, match, match_cnt
  );
endinterface

`default_nettype wire

// File: rtl/seq_detector_ctrl.sv
// ============================================================================
//  Module   : seq_detector_ctrl
//  Brief    : Round-robin arbitrated controller for a shared serial pattern
//             detector: grant, pattern load, warm-up gating, match counting.
//             SEQ_CTRL_RESTART_EN selects non-overlapping detection.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_detector_ctrl #(
  parameter int WIDTH = 7,
  parameter int NREQ  = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_detector_ctrl_if.slave bus
);

  localparam int OWNER_W = $clog2(NREQ);
  localparam int WCNT_W  = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [WCNT_W-1:0]  WARM_LAST = WCNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [OWNER_W-1:0] LAST_REQ  = OWNER_W'(NREQ - 1);
  localparam logic [NREQ-1:0]    GNT_ONE   = NREQ'(1);

  logic [1:0]         r_state;
  logic [NREQ-1:0]    r_gnt;
  logic [OWNER_W-1:0] r_owner;
  logic [OWNER_W-1:0] r_ptr;
  logic [WIDTH-1:0]   r_pattern;
  logic [WIDTH-2:0]   r_shift;
  logic [WCNT_W-1:0]  r_warm_cnt;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_window;
  logic               w_match;
  logic               w_any_req;
  logic               w_release;
  logic               w_found;
  logic [OWNER_W-1:0] w_winner;
  logic [OWNER_W-1:0] w_ptr_next;
  logic [NREQ-1:0]    w_gnt_next;
  logic [WIDTH-1:0]   w_pattern_sel;
  int                 w_idx;

  // Oldest bit sits at the top, so pattern[WIDTH-1] meets the first bit sent.
  assign w_window  = {r_shift, bus.data_in};
  assign w_match   = (r_state == ST_RUN) && (w_window == r_pattern);
  assign w_any_req = |bus.req;
  assign w_release = (r_state != ST_IDLE) && !bus.req[r_owner];

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = OWNER_W'(w_idx);
      end
    end
  end

  assign w_ptr_next    = (w_winner == LAST_REQ) ? '0 : w_winner + 1'b1;
  assign w_gnt_next    = GNT_ONE << w_winner;
  assign w_pattern_sel = bus.req_seq[w_winner*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_pattern  <= '0;
      r_shift    <= '0;
      r_warm_cnt <= '0;
      r_cnt      <= '0;
    end else begin
      if (r_state != ST_IDLE) begin
        r_shift <= w_window[WIDTH-2:0];
      end
      // A match in the release cycle still lands here before the state drops.
      if (w_match && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state    <= ST_WARM;
            r_gnt      <= w_gnt_next;
            r_owner    <= w_winner;
            r_ptr      <= w_ptr_next;
            r_pattern  <= w_pattern_sel;
            r_shift    <= '0;
            r_warm_cnt <= '0;
            r_cnt      <= '0;
          end
        end

        ST_WARM: begin
          if (w_release) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
          end else if (r_warm_cnt == WARM_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_warm_cnt <= r_warm_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (w_release) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
          end
`ifdef SEQ_CTRL_RESTART_EN
          else if (w_match) begin
            r_state    <= ST_WARM;
            r_shift    <= '0;
            r_warm_cnt <= '0;
          end
`endif
        end

        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.owner     = r_owner;
  assign bus.active    = (r_state != ST_IDLE);
  assign bus.match     = w_match;
  assign bus.match_cnt = r_cnt;

endmodule

`default_nettype wire

// File: doc/seq_detector_ctrl.md
# seq_detector_ctrl

Arbitrated controller for a shared serial pattern-match datapath. Up to `NREQ` requesters compete for one detector. The winner's pattern is loaded, the history window is warmed up, and matches on `data_in` are detected and counted until the owner releases. It sits in front of the sequence-detector datapath and owns its sequencing: pattern load, warm-up gating, match counting and hand-over between clients.

## Interface
- `WIDTH`, 7: pattern/window length in bits; must be at least 2.
- `NREQ`, 2: number of requesters; must be at least 2.
- `CNT_W`, 8: match counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in `NREQ`: per-requester session request, level; held for the whole session.
- `req_seq` in `NREQ*WIDTH`: pattern of requester i at bits `[i*WIDTH +: WIDTH]`.
- `data_in` in 1: serial input bit, one per cycle.
- `gnt` out `NREQ`: one-hot grant, registered.
- `owner` out `$clog2(NREQ)`: index of the current or most recent owner.
- `active` out 1: high in WARM and RUN.
- `match` out 1: combinational; high when the window equals the pattern in RUN.
- `match_cnt` out `CNT_W`: registered, saturating match count.

## Operation
- States are IDLE, WARM and RUN. Reset puts the block in IDLE with `gnt=0`, `owner=0`, `active=0`, `match=0`, `match_cnt=0`, shift register 0 and round-robin pointer 0.
- Window definition:
  - `window[0]=data_in` (live input).
  - `window[i]=shift[i-1]`, which is `data_in` from i cycles earlier.
  - `shift` is `WIDTH-1` bits, shifting in `data_in` every cycle in WARM and RUN and holding in IDLE.
- IDLE to WARM (the grant edge):
  - Taken when any `req` bit is high. The winner is the first requesting index at or after `pointer`, wrapping.
  - At this edge: `gnt[winner]=1`, `owner=winner`, the pattern is latched from `req_seq`, and `shift`, `match_cnt` and the warm counter are all cleared. `pointer` is set to `winner+1` modulo `NREQ`.
  - `req_seq` is sampled only at this edge. Later changes are ignored for the rest of the session.
- WARM to RUN: taken after exactly `WIDTH-1` cycles in WARM. `match` is forced 0 in WARM.
- RUN: `match = (window == pattern)`. On each match cycle `match_cnt` increments at the next edge and holds at `2^CNT_W-1`.
- Release: owner `req` low in WARM or RUN returns the block to IDLE at the next edge.
  - `gnt` and `active` clear at that edge.
  - `match_cnt` and `owner` hold until the next grant.
  - A `match` in the release cycle is still counted.
- Requests from non-owners are ignored during a session. There is no preemption.
- Reset mid-session: immediate return to IDLE with all reset values; the session is lost.

## Timing
- Grant latency: `req` high in IDLE at cycle t gives `gnt` high from t+1.
- Warm-up: cycles t+1 .. t+WIDTH-1 are WARM. The first RUN cycle is t+WIDTH, and `data_in` from t+1 onward fills the window.
- `match` is valid in the same cycle as the final pattern bit. `match_cnt` reflects it one cycle later.
- Hand-over: release at edge e leaves the block in IDLE for one cycle; the next grant is at edge e+1. Minimum gap between sessions is one idle cycle.
- Bit order: `pattern[WIDTH-1]` is compared against the oldest bit, so the stream is sent MSB first.

## Configuration
- Macro: `SEQ_CTRL_RESTART_EN`.
- Defined: non-overlapping detection. A match cycle in RUN transitions to WARM, clears `shift` and the warm counter, and keeps the pattern and `match_cnt`. The next match is possible no earlier than `WIDTH` cycles after the previous one.
- Undefined: overlapping detection. RUN stays in RUN, and matches can occur on consecutive cycles.

## Test plan
- Basic match: reset, then `req=2'b01` and `req_seq[6:0]=7'b1011001`; after the grant, drive 1,0,1,1,0,0,1. `match=1` on the 7th data cycle (first RUN cycle), then `match_cnt=1`.
- Warm-up gating: grant requester 0 with pattern 7'b0000000 and `data_in=0` constant. `match=0` for 6 WARM cycles, then 1 every RUN cycle (macro off), or every 7th cycle (macro on).
- Round-robin: hold `req=2'b11` and release each owner after 3 cycles. Grants alternate 0,1,0,1 with one IDLE cycle between sessions, and `pattern` follows the owner's `req_seq`.
- Saturation: `CNT_W=2`, pattern all-ones, `data_in=1`, macro off. `match_cnt` goes 1,2,3 and stays at 3.
- Mid-session release and reset:
  - Owner drops `req` in WARM: `gnt` clears next edge and `match_cnt` holds.
  - `rst_n` low in RUN: all outputs go to 0 asynchronously, and the next grant goes to requester 0.
- Restart macro: with `SEQ_CTRL_RESTART_EN`, pattern 7'b1111111 and `data_in=1` for 20 RUN-phase cycles gives matches exactly 7 cycles apart.
